uart_wb_responder: RTL and testbench

//  Wishbone classic (non-pipelined) slave responder: the target end of the host bus the

---
 rtl/uart_wb_pkg.sv | 31 +++
 rtl/uart_wb_regbank.sv | 69 ++++++
 rtl/uart_wb_responder.sv | 126 ++++++++++++
 tb/tb_uart_wb_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the uart_wb_responder Wishbone target.
// Optional error termination is enabled by defining UART_WB_RESP_ERR_EN.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam int WAIT_W  = 4;
    localparam int INT_BIT = 0;

    localparam logic [2:0] REG_SCR0     = 3'd0;
    localparam logic [2:0] REG_SCR1     = 3'd1;
    localparam logic [2:0] REG_SCR2     = 3'd2;
    localparam logic [2:0] REG_SCR3     = 3'd3;
    localparam logic [2:0] REG_INT_EN   = 3'd4;
    localparam logic [2:0] REG_DOORBELL = 3'd5;
    localparam logic [2:0] REG_INT_STAT = 3'd6;
    localparam logic [2:0] REG_ID       = 3'd7;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_wb_regbank.sv
// Register file behind the Wishbone responder: byte-lane writes, read mux,
// doorbell-driven sticky interrupt status and the registered interrupt output.
module uart_wb_regbank
    import uart_wb_pkg::*;
#(
    parameter logic [31:0] RESP_ID = 32'h5541_5254
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_dat,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_dat,
    output logic        irq
);

    logic [31:0] scratch [4];
    logic [31:0] doorbell;
    logic        int_en;
    logic        int_stat;
    logic [31:0] wr_mask;

    assign wr_mask = lane_mask(wr_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                scratch[i] <= '0;
            end
            doorbell <= '0;
            int_en   <= 1'b0;
            int_stat <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= int_stat & int_en;
            if (wr_en) begin
                case (wr_idx)
                    REG_SCR0, REG_SCR1, REG_SCR2, REG_SCR3:
                        scratch[wr_idx[1:0]] <= (scratch[wr_idx[1:0]] & ~wr_mask) | (wr_dat & wr_mask);
                    REG_INT_EN:
                        if (wr_sel[0]) int_en <= wr_dat[INT_BIT];
                    REG_DOORBELL: begin
                        doorbell <= (doorbell & ~wr_mask) | (wr_dat & wr_mask);
                        // only bytes actually written count as the rung value
                        if ((wr_dat & wr_mask) != '0) int_stat <= 1'b1;
                    end
                    REG_INT_STAT:
                        if (wr_sel[0] && wr_dat[INT_BIT]) int_stat <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        case (rd_idx)
            REG_SCR0, REG_SCR1, REG_SCR2, REG_SCR3: rd_dat = scratch[rd_idx[1:0]];
            REG_INT_EN:   rd_dat = {31'b0, int_en};
            REG_DOORBELL: rd_dat = doorbell;
            REG_INT_STAT: rd_dat = {31'b0, int_stat};
            REG_ID:       rd_dat = RESP_ID;
            default:      rd_dat = '0;
        endcase
    end

endmodule

// File: rtl/uart_wb_responder.sv
// Wishbone classic slave responder with programmable wait states and doorbell interrupt.
// Define UART_WB_RESP_ERR_EN to add wb_err_o for ID writes and empty-sel accesses.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for cyc&stb; request captured on the sampling edge
// ST_WAIT | counting wait states down; cyc low aborts the transfer
// ST_ACK  | ack/err pulse cycle; a write commits on the edge leaving it
module uart_wb_responder
    import uart_wb_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESP_ID     = 32'h5541_5254
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
`ifdef UART_WB_RESP_ERR_EN
    output logic        wb_err_o,
`endif
    output logic        int_o
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        cap_idx;
    logic              cap_we;
    logic [3:0]        cap_sel;
    logic [31:0]       cap_dat;

    logic [2:0]  req_idx;
    logic        req_we;
    logic [3:0]  req_sel;
    logic        req_err;
    logic        req_valid;
    logic        respond;
    logic        wr_en;
    logic [31:0] rd_dat;
    logic [1:0]  addr_unused;

    assign addr_unused = wb_addr_i[1:0];
    assign req_valid   = wb_cyc_i & wb_stb_i;

    // In IDLE the live bus is the request; afterwards the captured copy is.
    assign req_idx = (state == ST_IDLE) ? wb_addr_i[4:2] : cap_idx;
    assign req_we  = (state == ST_IDLE) ? wb_we_i        : cap_we;
    assign req_sel = (state == ST_IDLE) ? wb_sel_i       : cap_sel;

`ifdef UART_WB_RESP_ERR_EN
    assign req_err = (req_we && req_idx == REG_ID) || (req_sel == 4'b0);
`else
    assign req_err = 1'b0;
`endif

    assign respond = ((state == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && wb_cyc_i && (wait_cnt == '0));

    assign wr_en = (state == ST_ACK) && cap_we && !req_err;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            cap_idx  <= '0;
            cap_we   <= 1'b0;
            cap_sel  <= '0;
            cap_dat  <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
`ifdef UART_WB_RESP_ERR_EN
            wb_err_o <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_idx  <= wb_addr_i[4:2];
                        cap_we   <= wb_we_i;
                        cap_sel  <= wb_sel_i;
                        cap_dat  <= wb_dat_i;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i)             state    <= ST_IDLE;
                    else if (wait_cnt == '0)   state    <= ST_ACK;
                    else                       wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            wb_ack_o <= respond && !req_err;
            wb_dat_o <= (respond && !req_we && !req_err) ? rd_dat : '0;
`ifdef UART_WB_RESP_ERR_EN
            wb_err_o <= respond && req_err;
`endif
        end
    end

    uart_wb_regbank #(
        .RESP_ID (RESP_ID)
    ) u_regbank (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .wr_en  (wr_en),
        .wr_idx (cap_idx),
        .wr_sel (cap_sel),
        .wr_dat (cap_dat),
        .rd_idx (req_idx),
        .rd_dat (rd_dat),
        .irq    (int_o)
    );

endmodule

// File: tb/tb_uart_wb_responder.sv
// Directed bench for uart_wb_responder with WAIT_STATES=3.
// Error-termination checks are compiled only when UART_WB_RESP_ERR_EN is defined.
module tb_uart_wb_responder;

    localparam int          WS  = 3;
    localparam logic [31:0] RID = 32'h5541_5254;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        irq;
    logic        err_s;

    int checks = 0;
    int errors = 0;

`ifdef UART_WB_RESP_ERR_EN
    logic err;
    assign err_s = err;
`else
    assign err_s = 1'b0;
`endif

    uart_wb_responder #(
        .WAIT_STATES (WS),
        .RESP_ID     (RID)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_addr_i (addr),
        .wb_dat_i  (dat_w),
        .wb_dat_o  (dat_r),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_stb_i  (stb),
        .wb_cyc_i  (cyc),
        .wb_ack_o  (ack),
`ifdef UART_WB_RESP_ERR_EN
        .wb_err_o  (err),
`endif
        .int_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transfer; lat counts cycles after the sampling edge until ack/err.
    task automatic bus(input logic [4:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat,
                       output logic got_ack, output logic got_err);
        logic done;
        @(posedge clk); #1;
        addr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        done = 1'b0; lat = 0; rd = '0; got_ack = 1'b0; got_err = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (ack || err_s) begin
                done = 1'b1; lat = k; rd = dat_r; got_ack = ack; got_err = err_s;
            end
        end
        if (!done) chk("bus_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int lat; logic ga, ge;
        bus(a, 1'b1, d, s, rd, lat, ga, ge);
        chk({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        chk({tag, "_ack"}, {31'b0, ga}, 32'd1);
        chk({tag, "_dat0"}, rd, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] rd; int lat; logic ga, ge;
        bus(a, 1'b0, 32'd0, 4'hF, rd, lat, ga, ge);
        chk({tag, "_lat"}, 32'(lat), 32'(WS + 1));
        chk(tag, rd, exp);
    endtask

    initial begin
        int ack_cnt;
        int ack_pos [2];
        logic [31:0] rd; int lat; logic ga, ge;

        rst = 1'b1; addr = '0; dat_w = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
        #12;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_int", {31'b0, irq}, 32'd0);
        chk("rst_err", {31'b0, err_s}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // reset in the middle of a WAIT phase drops the transfer and clears registers
        wr("pre_r0", 5'h00, 32'hA5A5_A5A5, 4'hF);
        rd_chk("pre_r0_rd", 5'h00, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        addr = 5'h00; we = 1'b1; dat_w = 32'h1111_1111; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk); @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #1;
        chk("midrst_ack", {31'b0, ack}, 32'd0);
        chk("midrst_dat", dat_r, 32'd0);
        chk("midrst_int", {31'b0, irq}, 32'd0);
        @(negedge clk); rst = 1'b0;
        ga = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) ga = 1'b1;
        end
        chk("midrst_noack", {31'b0, ga}, 32'd0);
        rd_chk("midrst_r0", 5'h00, 32'h0);

        // byte-lane write
        rd_chk("r1_init", 5'h04, 32'h0);
        wr("r1_wr", 5'h04, 32'hDEAD_BEEF, 4'b0101);
        rd_chk("r1_lanes", 5'h04, 32'h00AD_00EF);
        wr("r1_wr_hi", 5'h07, 32'h1234_5678, 4'b1000);
        rd_chk("r1_lanes_hi", 5'h04, 32'h12AD_00EF);

        // held strobe: acks at cycle WS+1 and every WS+2 after that
        @(posedge clk); #1;
        addr = 5'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        ack_cnt = 0; ack_pos[0] = 0; ack_pos[1] = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (ack) begin
                if (ack_cnt < 2) ack_pos[ack_cnt] = k;
                ack_cnt++;
            end
        end
        @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
        chk("held_cnt", 32'(ack_cnt), 32'd2);
        chk("held_pos0", 32'(ack_pos[0]), 32'd4);
        chk("held_pos1", 32'(ack_pos[1]), 32'd9);
        repeat (3) @(posedge clk);

        // doorbell interrupt
        wr("inten_wr", 5'h10, 32'hFFFF_FFFF, 4'hF);
        rd_chk("inten_rd", 5'h10, 32'h1);
        wr("door_wr", 5'h14, 32'h0000_0001, 4'hF);
        @(negedge clk); @(negedge clk);
        chk("int_set", {31'b0, irq}, 32'd1);
        rd_chk("stat_set", 5'h18, 32'h1);
        rd_chk("door_rd", 5'h14, 32'h1);
        wr("stat_clr", 5'h18, 32'h0000_0001, 4'hF);
        @(negedge clk); @(negedge clk);
        chk("int_clr", {31'b0, irq}, 32'd0);
        rd_chk("stat_clr_rd", 5'h18, 32'h0);
        // zero doorbell value does not ring
        wr("door_zero", 5'h14, 32'h0000_0000, 4'hF);
        @(negedge clk); @(negedge clk);
        chk("int_zero", {31'b0, irq}, 32'd0);

        // abort in second WAIT cycle
        wr("r0_set", 5'h00, 32'hCAFE_F00D, 4'hF);
        @(posedge clk); #1;
        addr = 5'h00; we = 1'b1; dat_w = 32'h1234_5678; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        ga = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack || err_s) ga = 1'b1;
        end
        chk("abort_noack", {31'b0, ga}, 32'd0);
        rd_chk("abort_r0", 5'h00, 32'hCAFE_F00D);

        rd_chk("id_rd", 5'h1C, 32'h5541_5254);
`ifdef UART_WB_RESP_ERR_EN
        bus(5'h1C, 1'b1, 32'h0, 4'hF, rd, lat, ga, ge);
        chk("id_wr_err", {31'b0, ge}, 32'd1);
        chk("id_wr_ack", {31'b0, ga}, 32'd0);
        chk("id_wr_lat", 32'(lat), 32'(WS + 1));
        bus(5'h08, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, lat, ga, ge);
        chk("sel0_err", {31'b0, ge}, 32'd1);
        chk("sel0_ack", {31'b0, ga}, 32'd0);
`else
        bus(5'h1C, 1'b1, 32'h0, 4'hF, rd, lat, ga, ge);
        chk("id_wr_ack", {31'b0, ga}, 32'd1);
        chk("id_wr_lat", 32'(lat), 32'(WS + 1));
        wr("sel0_wr", 5'h08, 32'hFFFF_FFFF, 4'h0);
`endif
        rd_chk("id_rd2", 5'h1C, 32'h5541_5254);
        rd_chk("r2_sel0", 5'h08, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
